// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: bursts of num_pkts packets of pkt_len beats with an idle gap.
// Define AXIS_GEN_LFSR_EN to source tdata from an 8-bit LFSR instead of a byte counter.
module axis_pkt_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [7:0]        num_pkts,
    input  logic [GAP_W-1:0]  gap,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pkt_count,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tkeep,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

`ifdef AXIS_GEN_LFSR_EN
    localparam logic [DATA_W-1:0] DATA_SEED = DATA_W'(8'h01);
`else
    localparam logic [DATA_W-1:0] DATA_SEED = '0;
`endif

    // Payload sequence step: x^8+x^6+x^5+x^4+1 Fibonacci LFSR, or a wrapping counter.
    function automatic logic [DATA_W-1:0] next_data(input logic [DATA_W-1:0] d);
`ifdef AXIS_GEN_LFSR_EN
        logic [DATA_W-1:0] n;
        n      = '0;
        n[7:0] = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
        return n;
`else
        return d + DATA_W'(1);
`endif
    endfunction

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [7:0]         num_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [LEN_W-1:0]   beat_idx;
    logic [DATA_W-1:0]  data_cnt;
    logic [DATA_W-1:0]  data_nxt;

    assign data_nxt     = next_data(data_cnt);
    assign m_axis_tkeep = m_axis_tvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            len_q         <= '0;
            num_q         <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            beat_idx      <= '0;
            data_cnt      <= DATA_SEED;
            pkt_count     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && (pkt_len != '0) && (num_pkts != '0)) begin
                        len_q         <= pkt_len;
                        num_q         <= num_pkts;
                        gap_q         <= gap;
                        pkt_count     <= '0;
                        beat_idx      <= '0;
                        busy          <= 1'b1;
                        state         <= S_SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= data_cnt;
                        m_axis_tlast  <= (pkt_len == LEN_W'(1));
                    end
                end
                S_SEND: begin
                    // Outputs only move on an accepted beat, which keeps them stable under backpressure.
                    if (m_axis_tready) begin
                        data_cnt <= data_nxt;
                        if (m_axis_tlast) begin
                            pkt_count <= pkt_count + 8'd1;
                            beat_idx  <= '0;
                            if (pkt_count == num_q - 8'd1) begin
                                state         <= S_IDLE;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tdata  <= '0;
                                m_axis_tlast  <= 1'b0;
                            end else if (gap_q != '0) begin
                                state         <= S_GAP;
                                gap_cnt       <= gap_q;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tdata  <= '0;
                                m_axis_tlast  <= 1'b0;
                            end else begin
                                m_axis_tdata <= data_nxt;
                                m_axis_tlast <= (len_q == LEN_W'(1));
                            end
                        end else begin
                            beat_idx     <= beat_idx + LEN_W'(1);
                            m_axis_tdata <= data_nxt;
                            m_axis_tlast <= (beat_idx + LEN_W'(1) == len_q - LEN_W'(1));
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state         <= S_SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= data_cnt;
                        m_axis_tlast  <= (len_q == LEN_W'(1));
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: vector table of bursts plus reset and re-start sequences.
module tb_axis_pkt_gen;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       start;
    logic [7:0] pkt_len;
    logic [7:0] num_pkts;
    logic [3:0] gap;
    logic       busy;
    logic       done;
    logic [7:0] pkt_count;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tkeep;
    logic       m_axis_tlast;
    logic       m_axis_tready;

    always #5 aclk = ~aclk;

    axis_pkt_gen #(.DATA_W(8), .LEN_W(8), .GAP_W(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .pkt_len       (pkt_len),
        .num_pkts      (num_pkts),
        .gap           (gap),
        .busy          (busy),
        .done          (done),
        .pkt_count     (pkt_count),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    // mode: 0 = tready always high, 1 = hold tready low 3 cycles on beat 2, 2 = random tready
    typedef struct {
        int len;
        int num;
        int gap;
        int mode;
        bit poke;
        int exp_pkts;
        int exp_done;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] sb[$];
    logic [7:0] exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] d);
`ifdef AXIS_GEN_LFSR_EN
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
        return d + 8'd1;
`endif
    endfunction

    function automatic logic [7:0] model_seed();
`ifdef AXIS_GEN_LFSR_EN
        return 8'h01;
`else
        return 8'h00;
`endif
    endfunction

    task automatic run_burst(input vec_t v);
        int         cyc = 0;
        int         dones = 0;
        int         post = 0;
        int         valid_cycles = 0;
        int         zero_run = 0;
        int         bp_state = 0;
        int         bp_cnt = 0;
        bit         in_gap = 0;
        bit         held = 0;
        bit         finished = 0;
        bit         active;
        logic [8:0] hv;
        logic [8:0] got;
        logic [8:0] want;
        logic [7:0] bp_val;
        logic [7:0] d;

        active = (v.exp_done != 0);
        d = exp_data;
        if (active) begin
            for (int p = 0; p < v.num; p++)
                for (int b = 0; b < v.len; b++) begin
                    if (p == 0 && b == 2) bp_val = d;
                    sb.push_back({(b == v.len - 1), d});
                    d = model_next(d);
                end
            exp_data = d;
        end

        @(posedge aclk); #1;
        start = 1'b1; pkt_len = 8'(v.len); num_pkts = 8'(v.num); gap = 4'(v.gap);
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0; pkt_len = 8'($urandom); num_pkts = 8'($urandom); gap = 4'($urandom);
        chk("start_latency_tvalid", m_axis_tvalid, active);
        chk("start_latency_busy", busy, active);
        if (v.mode == 1 && m_axis_tvalid && m_axis_tdata == bp_val) bp_state = 1;
        if (bp_state == 1) begin m_axis_tready = 1'b0; bp_state = 2; end

        while (!finished && cyc < 4000) begin
            @(negedge aclk);
            chk("tkeep_eq_tvalid", m_axis_tkeep, m_axis_tvalid);
            if (held) chk("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hv});
            if (!m_axis_tvalid) chk("idle_zero", {m_axis_tlast, m_axis_tdata}, 9'h000);
            held = m_axis_tvalid && !m_axis_tready;
            hv = {m_axis_tlast, m_axis_tdata};
            if (v.mode == 1 && m_axis_tvalid && m_axis_tdata == bp_val) bp_cnt++;
            if (m_axis_tvalid) begin
                valid_cycles++;
                if (in_gap) chk("gap_len", zero_run, v.gap);
                in_gap = 0;
            end else if (in_gap) begin
                zero_run++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got = {m_axis_tlast, m_axis_tdata};
                if (sb.size() == 0) fail_now("extra_beat");
                else begin
                    want = sb.pop_front();
                    chk("beat_last_data", got, want);
                end
                if (m_axis_tlast && sb.size() != 0) begin
                    in_gap = 1;
                    zero_run = 0;
                end
            end
            if (done) begin
                dones++;
                chk("done_busy_low", busy, 0);
                chk("done_pkt_count", pkt_count, v.exp_pkts);
                chk("done_sb_empty", sb.size(), 0);
            end
            if (dones > 0) post++;
            if (post >= 3) finished = 1;
            if (!active && cyc >= 12) finished = 1;

            @(posedge aclk); #1;
            case (v.mode)
                1: begin
                    if (bp_state == 0 && m_axis_tvalid && m_axis_tdata == bp_val) bp_state = 1;
                    if (bp_state >= 1 && bp_state <= 3) begin
                        m_axis_tready = 1'b0;
                        bp_state++;
                    end else m_axis_tready = 1'b1;
                end
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
            if (v.poke && cyc == 3) begin
                start = 1'b1; pkt_len = 8'd9; num_pkts = 8'd5; gap = 4'd0;
            end else start = 1'b0;
            cyc++;
        end

        if (!finished) fail_now("burst_timeout");
        chk("done_pulses", dones, v.exp_done);
        chk("sb_drained", sb.size(), 0);
        chk("busy_after", busy, 0);
        if (!active) chk("ignored_no_valid", valid_cycles, 0);
        if (v.mode == 1) chk("backpressure_hold_cycles", bp_cnt, 4);
        sb.delete();
        m_axis_tready = 1'b1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{len: 4,  num: 1, gap: 0,  mode: 0, poke: 0, exp_pkts: 1, exp_done: 1};
        vecs[1] = '{len: 5,  num: 1, gap: 0,  mode: 1, poke: 0, exp_pkts: 1, exp_done: 1};
        vecs[2] = '{len: 3,  num: 2, gap: 2,  mode: 0, poke: 0, exp_pkts: 2, exp_done: 1};
        vecs[3] = '{len: 20, num: 1, gap: 0,  mode: 0, poke: 0, exp_pkts: 1, exp_done: 1};
        vecs[4] = '{len: 0,  num: 1, gap: 0,  mode: 0, poke: 0, exp_pkts: 0, exp_done: 0};
        vecs[5] = '{len: 3,  num: 0, gap: 0,  mode: 0, poke: 0, exp_pkts: 0, exp_done: 0};
        vecs[6] = '{len: 4,  num: 2, gap: 1,  mode: 0, poke: 1, exp_pkts: 2, exp_done: 1};
        vecs[7] = '{len: 1,  num: 3, gap: 0,  mode: 2, poke: 0, exp_pkts: 3, exp_done: 1};
        vecs[8] = '{len: 6,  num: 3, gap: 1,  mode: 2, poke: 0, exp_pkts: 3, exp_done: 1};
        vecs[9] = '{len: 2,  num: 2, gap: 15, mode: 0, poke: 0, exp_pkts: 2, exp_done: 1};

        aresetn = 1'b0; start = 1'b0; pkt_len = '0; num_pkts = '0; gap = '0;
        m_axis_tready = 1'b1;
        exp_data = model_seed();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, done},
            5'b0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 10; i++) run_burst(vecs[i]);

        // Reset in the middle of a packet, then a fresh short burst.
        @(posedge aclk); #1;
        start = 1'b1; pkt_len = 8'd8; num_pkts = 8'd1; gap = 4'd0; m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("midpkt_beat2", {m_axis_tvalid, m_axis_tdata},
            {1'b1, model_next(model_next(exp_data))});
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("midpkt_rst_drop", {m_axis_tvalid, m_axis_tlast, busy, done}, 4'b0);
        chk("midpkt_rst_tdata", m_axis_tdata, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_data = model_seed();
        run_burst('{len: 2, num: 1, gap: 0, mode: 0, poke: 0, exp_pkts: 1, exp_done: 1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
